// File: rtl/reg_scoreboard_dec_if.sv
// Issue/writeback/query bundle between the issue stage and the register-busy scoreboard.
interface reg_scoreboard_dec_if #(
   parameter int AW = 5
);
   localparam int NREG = 1 << AW;

   logic            flush;
   logic            set_en;
   logic [AW-1:0]   set_addr;
   logic            set_ack;
   logic            clr_en;
   logic [AW-1:0]   clr_addr;
   logic [AW-1:0]   rs_addr;
   logic [AW-1:0]   rt_addr;
   logic            rs_busy;
   logic            rt_busy;
   logic [NREG-1:0] busy_vec;
   logic [AW:0]     busy_cnt;
   logic            clr_err;

   modport master (
      output flush, set_en, set_addr, clr_en, clr_addr, rs_addr, rt_addr,
      input  set_ack, rs_busy, rt_busy, busy_vec, busy_cnt, clr_err
   );

   modport slave (
      input  flush, set_en, set_addr, clr_en, clr_addr, rs_addr, rt_addr,
      output set_ack, rs_busy, rt_busy, busy_vec, busy_cnt, clr_err
   );
endinterface

// File: rtl/reg_scoreboard_dec.sv
// Register-busy scoreboard: one busy bit per architectural register, set on issue,
// cleared on writeback, with two bypassed hazard queries and a running occupancy count.
module reg_scoreboard_dec #(
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_scoreboard_dec_if.slave   sb
);
   localparam int NREG = 1 << AW;

   logic [NREG-1:0] busy_vec_q, busy_vec_d;
   logic [AW:0]     busy_cnt_q, busy_cnt_d;
   logic            clr_err_q,  clr_err_d;

   logic [NREG-1:0] set_oh, clr_oh;
   logic            set_ack;
   logic            set_applied, clr_applied;
   logic            rs_byp, rt_byp;

   // A WAW on a busy register is only accepted when that register retires this same cycle.
   assign set_ack = sb.set_en &
                    (~busy_vec_q[sb.set_addr] | (sb.clr_en & (sb.clr_addr == sb.set_addr)));

   always_comb begin
      set_oh = '0;
      clr_oh = '0;
      for (int i = 0; i < NREG; i++) begin
         set_oh[i] = set_ack   & (sb.set_addr == AW'(i));
         clr_oh[i] = sb.clr_en & (sb.clr_addr == AW'(i));
      end
      if (ZERO_REG) begin
         set_oh[0] = 1'b0;
         clr_oh[0] = 1'b0;
      end
   end

   // At most one bit of each one-hot is set, so OR-reduction yields the single-step delta.
   assign set_applied = |(set_oh & ~busy_vec_q);
   assign clr_applied = |(clr_oh & busy_vec_q & ~set_oh);

   always_comb begin
      busy_vec_d = '0;
      busy_cnt_d = '0;
      if (!sb.flush) begin
         busy_vec_d = (busy_vec_q & ~clr_oh) | set_oh;
         busy_cnt_d = busy_cnt_q + (AW+1)'(set_applied) - (AW+1)'(clr_applied);
      end
   end

   assign clr_err_d = sb.clr_en & ~busy_vec_q[sb.clr_addr] &
                      ~(ZERO_REG & (sb.clr_addr == '0)) & ~sb.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec_q <= '0;
         busy_cnt_q <= '0;
         clr_err_q  <= 1'b0;
      end else begin
         busy_vec_q <= busy_vec_d;
         busy_cnt_q <= busy_cnt_d;
         clr_err_q  <= clr_err_d;
      end
   end

   assign rs_byp = BYPASS & sb.clr_en & (sb.clr_addr == sb.rs_addr);
   assign rt_byp = BYPASS & sb.clr_en & (sb.clr_addr == sb.rt_addr);

   assign sb.rs_busy  = busy_vec_q[sb.rs_addr] & ~rs_byp &
                        ~(ZERO_REG & (sb.rs_addr == '0));
   assign sb.rt_busy  = busy_vec_q[sb.rt_addr] & ~rt_byp &
                        ~(ZERO_REG & (sb.rt_addr == '0));
   assign sb.set_ack  = set_ack;
   assign sb.busy_vec = busy_vec_q;
   assign sb.busy_cnt = busy_cnt_q;
   assign sb.clr_err  = clr_err_q;
endmodule

// File: tb/tb_reg_scoreboard_dec.sv
// Directed bench for reg_scoreboard_dec (AW=5, ZERO_REG=1, BYPASS=1).
module tb_reg_scoreboard_dec;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   reg_scoreboard_dec_if #(.AW(5)) sb_if ();

   reg_scoreboard_dec #(.AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sb_if.flush    = 1'b0;
      sb_if.set_en   = 1'b0;
      sb_if.set_addr = '0;
      sb_if.clr_en   = 1'b0;
      sb_if.clr_addr = '0;
   endtask

   task automatic do_set(input logic [4:0] a);
      idle();
      sb_if.set_en   = 1'b1;
      sb_if.set_addr = a;
      tick();
   endtask

   task automatic do_clr(input logic [4:0] a);
      idle();
      sb_if.clr_en   = 1'b1;
      sb_if.clr_addr = a;
      tick();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      idle();
      sb_if.rs_addr = '0;
      sb_if.rt_addr = '0;
      rst_n = 1'b0;
      #12;
      sb_if.set_en   = 1'b1;
      sb_if.set_addr = 5'd4;
      #1;
      chk("rst_vec",    32'(sb_if.busy_vec), 32'h0);
      chk("rst_cnt",    32'(sb_if.busy_cnt), 32'd0);
      chk("rst_err",    32'(sb_if.clr_err),  32'd0);
      chk("rst_rs",     32'(sb_if.rs_busy),  32'd0);
      chk("rst_ack",    32'(sb_if.set_ack),  32'd1);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Issue to reg 5
      sb_if.set_en = 1'b1; sb_if.set_addr = 5'd5; #1;
      chk("set5_ack",  32'(sb_if.set_ack), 32'd1);
      tick();
      idle();
      sb_if.rs_addr = 5'd5; #1;
      chk("set5_vec",  sb_if.busy_vec,     32'h0000_0020);
      chk("set5_cnt",  32'(sb_if.busy_cnt), 32'd1);
      chk("set5_rs",   32'(sb_if.rs_busy),  32'd1);

      // WAW refused, then accepted with same-cycle writeback
      sb_if.set_en = 1'b1; sb_if.set_addr = 5'd5; #1;
      chk("waw_nack",  32'(sb_if.set_ack), 32'd0);
      tick();
      chk("waw_vec",   sb_if.busy_vec,     32'h0000_0020);
      sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd5; #1;
      chk("waw_ack",   32'(sb_if.set_ack), 32'd1);
      chk("waw_byp",   32'(sb_if.rs_busy), 32'd0);
      tick();
      idle(); #1;
      chk("waw_vec2",  sb_if.busy_vec,     32'h0000_0020);
      chk("waw_cnt2",  32'(sb_if.busy_cnt), 32'd1);
      chk("waw_err",   32'(sb_if.clr_err),  32'd0);

      // Retire 5, issue 7, then bypassed writeback of 7
      do_clr(5'd5);
      chk("clr5_vec",  sb_if.busy_vec,     32'h0);
      chk("clr5_cnt",  32'(sb_if.busy_cnt), 32'd0);
      do_set(5'd7);
      idle();
      sb_if.rt_addr = 5'd7; #1;
      chk("rt7_busy",  32'(sb_if.rt_busy), 32'd1);
      sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd7; #1;
      chk("rt7_byp",   32'(sb_if.rt_busy), 32'd0);
      tick();
      idle(); #1;
      chk("clr7_vec",  sb_if.busy_vec,     32'h0);
      chk("clr7_cnt",  32'(sb_if.busy_cnt), 32'd0);

      // Register 0 is hardwired idle
      sb_if.set_en = 1'b1; sb_if.set_addr = 5'd0; #1;
      chk("z_ack",     32'(sb_if.set_ack), 32'd1);
      tick();
      chk("z_vec",     sb_if.busy_vec,     32'h0);
      chk("z_cnt",     32'(sb_if.busy_cnt), 32'd0);
      do_clr(5'd0);
      chk("z_err",     32'(sb_if.clr_err),  32'd0);
      idle();
      sb_if.rs_addr = 5'd0; #1;
      chk("z_rs",      32'(sb_if.rs_busy),  32'd0);

      // Simultaneous set of one register and retire of another keeps the count
      do_set(5'd2);
      idle();
      sb_if.set_en = 1'b1; sb_if.set_addr = 5'd4;
      sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd2;
      tick();
      chk("swap_vec",  sb_if.busy_vec,     32'h0000_0010);
      chk("swap_cnt",  32'(sb_if.busy_cnt), 32'd1);
      do_clr(5'd4);

      // Fill then flush
      for (int i = 1; i < 32; i++) do_set(5'(i));
      idle(); #1;
      chk("full_cnt",  32'(sb_if.busy_cnt), 32'd31);
      chk("full_vec",  sb_if.busy_vec,     32'hFFFF_FFFE);
      sb_if.flush = 1'b1; sb_if.set_en = 1'b1; sb_if.set_addr = 5'd3;
      sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd9; #1;
      chk("fl_ack",    32'(sb_if.set_ack), 32'd0);
      tick();
      idle(); #1;
      chk("fl_vec",    sb_if.busy_vec,     32'h0);
      chk("fl_cnt",    32'(sb_if.busy_cnt), 32'd0);
      chk("fl_err",    32'(sb_if.clr_err),  32'd0);

      // Erroneous clear pulses for one cycle
      do_clr(5'd9);
      chk("err_pulse", 32'(sb_if.clr_err),  32'd1);
      chk("err_vec",   sb_if.busy_vec,     32'h0);
      chk("err_cnt",   32'(sb_if.busy_cnt), 32'd0);
      idle();
      tick();
      chk("err_drop",  32'(sb_if.clr_err),  32'd0);

      // Asynchronous reset mid-operation
      do_set(5'd10);
      idle();
      sb_if.set_en = 1'b1; sb_if.set_addr = 5'd11;
      sb_if.clr_en = 1'b1; sb_if.clr_addr = 5'd12;
      tick();
      idle();
      sb_if.rs_addr = 5'd10; sb_if.rt_addr = 5'd11; #1;
      chk("pre_vec",   sb_if.busy_vec,     32'h0000_0C00);
      chk("pre_err",   32'(sb_if.clr_err),  32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar_vec",    sb_if.busy_vec,     32'h0);
      chk("ar_cnt",    32'(sb_if.busy_cnt), 32'd0);
      chk("ar_err",    32'(sb_if.clr_err),  32'd0);
      chk("ar_rs",     32'(sb_if.rs_busy),  32'd0);
      chk("ar_rt",     32'(sb_if.rt_busy),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_set(5'd1);
      chk("post_vec",  sb_if.busy_vec,     32'h0000_0002);
      chk("post_cnt",  32'(sb_if.busy_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
